// File: rtl/profile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : profile_ctrl
// Description : Custom-instruction command decoder for four profiling up-counters.
//               It drives counter enable and reset and returns counter or run status.
// Revision    : 1.0 - initial release
// ============================================================================
module profile_ctrl #(
  parameter int         WIDTH    = 32,
  parameter logic [7:0] customId = 8'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ciStart,
  input  logic             ciCke,
  input  logic [7:0]       ciN,
  input  logic [WIDTH-1:0] ciValueA,
  input  logic [WIDTH-1:0] ciValueB,
  output logic             ciDone,
  output logic [WIDTH-1:0] ciResult,
  input  logic             stallIn,
  input  logic             busIdleIn,
  input  logic             eventIn,
  input  logic [WIDTH-1:0] counterValue0,
  input  logic [WIDTH-1:0] counterValue1,
  input  logic [WIDTH-1:0] counterValue2,
  input  logic [WIDTH-1:0] counterValue3,
  output logic [3:0]       counterEnable,
  output logic [3:0]       counterReset,
  output logic             counterDir
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t           state;
  logic [3:0]       running;
  logic             accept;
  logic [3:0]       start_mask;
  logic [3:0]       stop_mask;
  logic [3:0]       reset_mask;
  logic [WIDTH-1:0] read_data;
  logic             unused_bits;

  assign accept     = ciStart & ciCke & (ciN == customId);
  assign start_mask = ciValueB[3:0];
  assign stop_mask  = ciValueB[7:4];
  assign reset_mask = ciValueB[11:8];

  // Only the select/status bits of A and the three 4-bit masks of B carry meaning.
  assign unused_bits = ^{ciValueA[WIDTH-1:3], ciValueB[WIDTH-1:12]};

  always_comb begin
    read_data = '0;
    if (ciValueA[2]) begin
      read_data = {{(WIDTH-4){1'b0}}, running};
    end else begin
      case (ciValueA[1:0])
        2'd0:    read_data = counterValue0;
        2'd1:    read_data = counterValue1;
        2'd2:    read_data = counterValue2;
        default: read_data = counterValue3;
      endcase
    end
  end

  // counterReset comes up all-ones so every counter clears on the first edge after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      running      <= 4'h0;
      ciDone       <= 1'b0;
      ciResult     <= '0;
      counterReset <= 4'hF;
    end else begin
      ciDone       <= 1'b0;
      ciResult     <= '0;
      counterReset <= 4'h0;
      case (state)
        S_IDLE:  state <= accept ? S_DONE : S_IDLE;
        S_DONE:  state <= accept ? S_DONE : S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (accept) begin
        ciDone       <= 1'b1;
        ciResult     <= read_data;
        running      <= (running | start_mask) & ~stop_mask;
        counterReset <= reset_mask;
      end
    end
  end

  assign counterEnable = running & {eventIn, busIdleIn, stallIn, 1'b1};
  assign counterDir    = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_profile_ctrl.sv
`default_nettype none
// Testbench for profile_ctrl: counter bank environment, reference model and result scoreboard.
module tb_profile_ctrl;

  localparam int         W  = 32;
  localparam logic [7:0] ID = 8'h5A;

  logic          clock = 1'b0;
  logic          reset;
  logic          ciStart, ciCke;
  logic [7:0]    ciN;
  logic [W-1:0]  ciValueA, ciValueB;
  logic          ciDone;
  logic [W-1:0]  ciResult;
  logic          stallIn, busIdleIn, eventIn;
  logic [W-1:0]  cnt [4];
  logic [3:0]    counterEnable, counterReset;
  logic          counterDir;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  logic [W-1:0]  exp_q [$];
  logic [3:0]    m_run, m_pend;
  logic [W-1:0]  m_cnt [4];
  logic [W-1:0]  m_nxt [4];
  logic [3:0]    m_ev;
  logic [W-1:0]  snap;

  always #5 clock = ~clock;

  profile_ctrl #(.WIDTH(W), .customId(ID)) dut (
    .clock(clock), .reset(reset),
    .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB),
    .ciDone(ciDone), .ciResult(ciResult),
    .stallIn(stallIn), .busIdleIn(busIdleIn), .eventIn(eventIn),
    .counterValue0(cnt[0]), .counterValue1(cnt[1]),
    .counterValue2(cnt[2]), .counterValue3(cnt[3]),
    .counterEnable(counterEnable), .counterReset(counterReset),
    .counterDir(counterDir)
  );

  // Counter bank the block controls: reset has priority over enable.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (counterReset[i])       cnt[i] <= '0;
      else if (counterEnable[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  // Reference model: what the counters and run flags should be after each edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run  = 4'h0;
      m_pend = 4'hF;
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
      exp_q.delete();
    end else begin
      m_ev = {eventIn, busIdleIn, stallIn, 1'b1};
      for (int i = 0; i < 4; i++)
        m_nxt[i] = m_pend[i] ? '0 : ((m_run[i] && m_ev[i]) ? m_cnt[i] + 1 : m_cnt[i]);
      if (ciStart && ciCke && ciN == ID) begin
        exp_q.push_back(ciValueA[2] ? {28'd0, m_run} : m_cnt[ciValueA[1:0]]);
        m_run  = (m_run | ciValueB[3:0]) & ~ciValueB[7:4];
        m_pend = ciValueB[11:8];
      end else begin
        m_pend = 4'h0;
      end
      for (int i = 0; i < 4; i++) m_cnt[i] = m_nxt[i];
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a done is owed exactly when the model queued a result on the previous edge.
  always @(negedge clock) begin
    chk("done", {31'd0, ciDone}, {31'd0, (exp_q.size() != 0)});
    if (ciDone && exp_q.size() != 0) chk("result", ciResult, exp_q.pop_front());
    else if (!ciDone)                chk("result_idle", ciResult, '0);
    chk("enable", {28'd0, counterEnable}, {28'd0, m_run & {eventIn, busIdleIn, stallIn, 1'b1}});
    chk("creset", {28'd0, counterReset}, {28'd0, m_pend});
    chk("dir", {31'd0, counterDir}, 32'd1);
    if (!reset)
      for (int i = 0; i < 4; i++) chk("count", cnt[i], m_cnt[i]);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] n);
    ciStart = 1'b1; ciCke = 1'b1; ciN = n; ciValueA = a; ciValueB = b;
    tick();
    ciStart = 1'b0; ciCke = 1'b0; ciValueA = '0; ciValueB = '0;
  endtask

  initial begin
    reset = 1'b1; ciStart = 1'b0; ciCke = 1'b0; ciN = ID;
    ciValueA = '0; ciValueB = '0; stallIn = 1'b0; busIdleIn = 1'b0; eventIn = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    chk("release_creset", {28'd0, counterReset}, 32'hF);
    chk("release_enable", {28'd0, counterEnable}, 32'h0);
    chk("release_done", {31'd0, ciDone}, 32'd0);
    tick();

    cmd(32'd0, 32'h001, ID);
    snap = cnt[0];
    repeat (10) tick();
    chk("c0_advance10", cnt[0] - snap, 32'd10);
    repeat (5) tick();
    cmd(32'd0, 32'h100, ID);
    tick();

    cmd(32'd0, 32'h202, ID);
    tick();
    stallIn = 1'b1;
    repeat (7) tick();
    stallIn = 1'b0;
    chk("c1_stall7", cnt[1], 32'd7);
    cmd(32'd0, 32'h020, ID);
    snap = cnt[1];
    stallIn = 1'b1;
    repeat (5) tick();
    stallIn = 1'b0;
    chk("c1_stopped", cnt[1], snap);

    cmd(32'd0, 32'h011, ID);
    cmd(32'd4, 32'h000, ID);
    tick();
    cmd(32'd0, 32'h004, ID);
    cmd(32'd4, 32'h000, ID);
    tick();
    cmd(32'd0, 32'h00F, ID + 8'd1);
    cmd(32'd4, 32'h000, ID);
    tick();

    // Reset while a done is pending: the done must be dropped.
    ciStart = 1'b1; ciCke = 1'b1; ciN = ID; ciValueA = 32'd4; ciValueB = 32'h00F;
    tick();
    ciStart = 1'b0; reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    for (int k = 0; k < 600; k++) begin
      ciStart   = ($urandom_range(0, 2) != 0);
      ciCke     = ($urandom_range(0, 5) != 0);
      ciN       = ($urandom_range(0, 4) == 0) ? ID + 8'd1 : ID;
      ciValueA  = $urandom;
      ciValueB  = $urandom;
      stallIn   = $urandom_range(0, 1) != 0;
      busIdleIn = $urandom_range(0, 1) != 0;
      eventIn   = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 150) == 0) reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    ciStart = 1'b0; ciCke = 1'b0;
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
